iir_zero_serial: RTL and testbench

//  Feed-forward (zero/numerator) section of the 7th-order IIR low-pass, serial structure.

---
 rtl/iir_pkg.sv | 22 ++
 rtl/iir_zero_serial_if.sv | 26 ++
 rtl/iir_mac.sv | 19 +
 rtl/iir_zero_serial.sv | 112 +++++++++++
 tb/tb_iir_zero_serial.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// Shared constants for the 7th-order IIR low-pass: widths, numerator coefficients
// and the serial-section FSM state type. Also used by the parallel pole section.
package iir_pkg;

   localparam int DATA_W = 12;
   localparam int COE_W  = 12;
   localparam int N_TAPS = 8;
   localparam int CNT_W  = $clog2(N_TAPS);
   localparam int PROD_W = DATA_W + COE_W;
   localparam int OUT_W  = PROD_W + $clog2(N_TAPS);

   // Binomial numerator, sum 512: unity DC gain after a 9-bit right shift downstream.
   localparam logic signed [COE_W-1:0] B_ZERO [0:N_TAPS-1] = '{
      12'sd4, 12'sd28, 12'sd84, 12'sd140, 12'sd140, 12'sd84, 12'sd28, 12'sd4
   };

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_t;

endpackage

// File: rtl/iir_zero_serial_if.sv
// Sample/result bus between the upstream sample source and the serial zero section.
interface iir_zero_serial_if;
   import iir_pkg::*;

   // din_valid is a one-cycle strobe with no ready: a sample offered while busy=1 is
   // dropped (and flagged on overrun when built in). dout_valid is a one-cycle strobe
   // that the consumer must take in that cycle; dout holds until the next result.
   logic                     din_valid;
   logic signed [DATA_W-1:0] din;
   logic                     busy;
   logic                     dout_valid;
   logic signed [OUT_W-1:0]  dout;
   logic                     overrun;
   state_t                   dbg_state;

   modport master (
      output din_valid, din,
      input  busy, dout_valid, dout, overrun, dbg_state
   );

   modport slave (
      input  din_valid, din,
      output busy, dout_valid, dout, overrun, dbg_state
   );

endinterface

// File: rtl/iir_mac.sv
// Combinational signed multiply-accumulate: sum_out = acc_in + a*b, full precision,
// product sign-extended to the accumulator width.
module iir_mac
   import iir_pkg::*;
(
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [COE_W-1:0]  b,
   input  logic signed [OUT_W-1:0]  acc_in,
   output logic signed [OUT_W-1:0]  sum_out
);

   logic signed [PROD_W-1:0] w_prod;
   logic signed [OUT_W-1:0]  w_prod_ext;

   assign w_prod     = a * b;
   assign w_prod_ext = {{(OUT_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   assign sum_out    = acc_in + w_prod_ext;

endmodule

// File: rtl/iir_zero_serial.sv
// Serial feed-forward section: y[n] = sum b_k*x[n-k] over 8 taps with one shared MAC.
// Optional sticky dropped-sample flag built when IIR_ZERO_OVERRUN_EN is defined.
module iir_zero_serial
   import iir_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   iir_zero_serial_if.slave  bus
);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_capture;
   logic                      w_last;

   logic signed [DATA_W-1:0]  r_x [0:N_TAPS-1];
   logic signed [OUT_W-1:0]   r_acc;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_busy;
   logic                      r_dout_valid;
   logic signed [OUT_W-1:0]   r_dout;

   logic signed [DATA_W-1:0]  w_x_sel;
   logic signed [COE_W-1:0]   w_coef;
   logic signed [OUT_W-1:0]   w_sum;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.din_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = MAC;
            end
         end
         MAC: begin
            if (r_cnt == CNT_W'(N_TAPS-1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_x_sel = r_x[r_cnt];
   assign w_coef  = B_ZERO[r_cnt];

   iir_mac u_mac (
      .a       (w_x_sel),
      .b       (w_coef),
      .acc_in  (r_acc),
      .sum_out (w_sum)
   );

   // Samples only enter the delay line from IDLE, so a strobe during MAC never shifts it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
      end else begin
         r_dout_valid <= 1'b0;
         if (w_capture) begin
            r_x[0] <= bus.din;
            for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_state == MAC) begin
            r_acc <= w_sum;
            if (w_last) begin
               r_dout       <= w_sum;
               r_dout_valid <= 1'b1;
               r_busy       <= 1'b0;
               r_cnt        <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef IIR_ZERO_OVERRUN_EN
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (!rst)                         r_overrun <= 1'b0;
      else if (bus.din_valid && r_busy) r_overrun <= 1'b1;
   end

   assign bus.overrun = r_overrun;
`else
   assign bus.overrun = 1'b0;
`endif

   assign bus.busy       = r_busy;
   assign bus.dout_valid = r_dout_valid;
   assign bus.dout       = r_dout;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_iir_zero_serial.sv
// Randomised self-checking bench for iir_zero_serial against a plain-arithmetic
// convolution model of the 8-tap numerator.
module tb_iir_zero_serial;
   import iir_pkg::*;

   localparam int DW = 12;
   localparam int OW = 27;
   localparam int COEF [0:7] = '{4, 28, 84, 140, 140, 84, 28, 4};
   localparam int IMP  [0:8] = '{4, 28, 84, 140, 140, 84, 28, 4, 0};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   iir_zero_serial_if bus ();

   iir_zero_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int          hist[$];
   logic [OW-1:0] exp_q[$];

   function automatic int model_push(input int v);
      int s;
      hist.push_front(v);
      if (hist.size() > 8) void'(hist.pop_back());
      s = 0;
      for (int k = 0; k < hist.size(); k++) s += COEF[k] * hist[k];
      return s;
   endfunction

   function automatic void model_reset();
      hist.delete();
   endfunction

   // Offers one sample when idle and watches win negedges after the capture edge.
   task automatic send_sample(input int v, input int win, output logic [OW-1:0] got,
                              output int lat, output int bc, output int dc);
      got = 'x;
      lat = -1;
      bc  = 0;
      dc  = 0;
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din       = DW'(v);
      for (int j = 0; j < win; j++) begin
         @(negedge clk);
         if (j == 0) bus.din_valid = 1'b0;
         if (bus.busy === 1'b1) bc++;
         if (bus.dout_valid === 1'b1) begin
            dc++;
            if (lat < 0) begin
               lat = j;
               got = bus.dout;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.din_valid = 1'b0;
      bus.din = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
      else n_pass++;
      n_checks++;
      if (bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid);
      else n_pass++;
      n_checks++;
      if (bus.dout !== '0) $display("FAIL reset_dout: got %0d want 0", $signed(bus.dout));
      else n_pass++;
      n_checks++;
      if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun);
      else n_pass++;
      n_checks++;
      if (bus.dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", bus.dbg_state);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", bus.busy);
      else n_pass++;
      model_reset();
   endtask

   task automatic test_impulse(input string tag);
      logic [OW-1:0] got;
      logic [OW-1:0] ev;
      int lat, bc, dc;
      for (int i = 0; i < 9; i++) begin
         void'(model_push((i == 0) ? 1 : 0));
         send_sample((i == 0) ? 1 : 0, 15, got, lat, bc, dc);
         ev = OW'(IMP[i]);
         n_checks++;
         if (got !== ev) $display("FAIL %s[%0d]: got %0d want %0d", tag, i, $signed(got), $signed(ev));
         else n_pass++;
      end
   endtask

   task automatic test_dc();
      logic [OW-1:0] got;
      logic [OW-1:0] ev;
      int lat, bc, dc, v;
      for (int pol = 0; pol < 2; pol++) begin
         v = (pol == 0) ? 2047 : -2048;
         for (int i = 0; i < 10; i++) begin
            ev = OW'(model_push(v));
            send_sample(v, 9, got, lat, bc, dc);
            n_checks++;
            if (got !== ev) $display("FAIL dc_model[%0d]: got %0d want %0d", i, $signed(got), $signed(ev));
            else n_pass++;
         end
         ev = (pol == 0) ? OW'(1048064) : OW'(-1048576);
         n_checks++;
         if (got !== ev) $display("FAIL dc_settle: got %0d want %0d", $signed(got), $signed(ev));
         else n_pass++;
      end
   endtask

   task automatic test_timing();
      logic [OW-1:0] got;
      logic [OW-1:0] ev;
      int lat, bc, dc, v;
      v = $urandom_range(0, 4095);
      if (v > 2047) v -= 4096;
      ev = OW'(model_push(v));
      send_sample(v, 12, got, lat, bc, dc);
      n_checks++;
      if (lat !== 8) $display("FAIL latency: got %0d want 8", lat);
      else n_pass++;
      n_checks++;
      if (bc !== 8) $display("FAIL busy_cycles: got %0d want 8", bc);
      else n_pass++;
      n_checks++;
      if (dc !== 1) $display("FAIL dout_valid_pulses: got %0d want 1", dc);
      else n_pass++;
      n_checks++;
      if (got !== ev) $display("FAIL timing_dout: got %0d want %0d", $signed(got), $signed(ev));
      else n_pass++;
   endtask

   // Minimum spacing: the next strobe lands on the edge right after completion.
   task automatic test_back_to_back();
      int vals[12];
      logic [OW-1:0] ev;
      int busy_bad;
      foreach (vals[i]) begin
         vals[i] = $urandom_range(0, 4095);
         if (vals[i] > 2047) vals[i] -= 4096;
      end
      busy_bad = 0;
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din = DW'(vals[0]);
      exp_q.push_back(OW'(model_push(vals[0])));
      for (int s = 0; s < 12; s++) begin
         for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j == 0) bus.din_valid = 1'b0;
            if (j < 8) begin
               if (bus.busy !== 1'b1) busy_bad++;
            end else begin
               ev = exp_q.pop_front();
               n_checks++;
               if (bus.dout_valid !== 1'b1 || bus.busy !== 1'b0 || bus.dout !== ev)
                  $display("FAIL b2b[%0d]: got dv=%b busy=%b dout=%0d want dv=1 busy=0 dout=%0d",
                           s, bus.dout_valid, bus.busy, $signed(bus.dout), $signed(ev));
               else n_pass++;
               if (s < 11) begin
                  bus.din_valid = 1'b1;
                  bus.din = DW'(vals[s+1]);
                  exp_q.push_back(OW'(model_push(vals[s+1])));
               end
            end
         end
      end
      n_checks++;
      if (busy_bad !== 0) $display("FAIL b2b_busy: got %0d low cycles want 0", busy_bad);
      else n_pass++;
   endtask

   task automatic test_overrun();
      logic [OW-1:0] got;
      logic [OW-1:0] ev;
      logic exp_ovr;
      int lat, bc, dc, v;
`ifdef IIR_ZERO_OVERRUN_EN
      exp_ovr = 1'b1;
`else
      exp_ovr = 1'b0;
`endif
      v = $urandom_range(1, 2047);
      ev = OW'(model_push(v));
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din = DW'(v);
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j == 0) bus.din_valid = 1'b0;
         if (j == 7) begin
            bus.din_valid = 1'b1;
            bus.din = DW'($urandom_range(0, 4095));
         end
         if (j == 8) begin
            bus.din_valid = 1'b0;
            n_checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== ev)
               $display("FAIL overrun_dout: got dv=%b dout=%0d want dv=1 dout=%0d",
                        bus.dout_valid, $signed(bus.dout), $signed(ev));
            else n_pass++;
         end
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.overrun !== exp_ovr) $display("FAIL overrun_flag: got %b want %b", bus.overrun, exp_ovr);
      else n_pass++;
      v = $urandom_range(0, 2047);
      ev = OW'(model_push(v));
      send_sample(v, 9, got, lat, bc, dc);
      n_checks++;
      if (got !== ev) $display("FAIL overrun_followup: got %0d want %0d", $signed(got), $signed(ev));
      else n_pass++;
   endtask

   task automatic test_reset_mid_mac();
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din = DW'($urandom_range(100, 2047));
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (j == 0) bus.din_valid = 1'b0;
         if (j == 3) rst = 1'b0;
         if (j == 4) begin
            n_checks++;
            if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.dout !== '0)
               $display("FAIL mid_reset: got busy=%b dv=%b dout=%0d want 0 0 0",
                        bus.busy, bus.dout_valid, $signed(bus.dout));
            else n_pass++;
            n_checks++;
            if (bus.overrun !== 1'b0) $display("FAIL mid_reset_overrun: got %b want 0", bus.overrun);
            else n_pass++;
            rst = 1'b1;
         end
      end
      model_reset();
      test_impulse("impulse_after_reset");
   endtask

   task automatic test_random();
      logic [OW-1:0] got;
      logic [OW-1:0] ev;
      int lat, bc, dc, v;
      for (int s = 0; s < 1000; s++) begin
         if (s % 50 == 7)       v = 2047;
         else if (s % 50 == 8)  v = -2048;
         else begin
            v = $urandom_range(0, 4095);
            if (v > 2047) v -= 4096;
         end
         exp_q.push_back(OW'(model_push(v)));
         send_sample(v, 9, got, lat, bc, dc);
         ev = exp_q.pop_front();
         n_checks++;
         if (got !== ev || dc !== 1)
            $display("FAIL random[%0d]: got %0d (pulses %0d) want %0d (pulses 1)", s, $signed(got), dc, $signed(ev));
         else n_pass++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.din_valid = 1'b0;
      bus.din = '0;
      test_reset();
      test_impulse("impulse");
      test_dc();
      test_timing();
      test_back_to_back();
      test_overrun();
      test_reset_mid_mac();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
